// File: rtl/uart_bus_pkg.sv
// Shared command/response encodings and FSM state type for the UART bus master.
package uart_bus_pkg;

    localparam logic [7:0] CMD_W = 8'h57;
    localparam logic [7:0] CMD_R = 8'h52;
    localparam logic [7:0] CMD_H = 8'h48;
    localparam logic [7:0] CMD_G = 8'h47;
    localparam logic [7:0] CMD_P = 8'h50;

    localparam logic [7:0] RSP_ACK = 8'h06;
    localparam logic [7:0] RSP_NAK = 8'h15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARGS,
        ST_EXEC_WR,
        ST_EXEC_RD,
        ST_SEND,
        ST_ACK,
        ST_NAK
    } state_t;

    // Response request: bytes are left-aligned, sent from [23:16] downward.
    typedef struct packed {
        logic [23:0] bytes;
        logic [1:0]  cnt;
    } tx_req_t;

endpackage

// File: rtl/uart_bus_master_tx_seq.sv
// Transmit front end: sends 1..3 queued bytes MSB first over the tbr_valid/tx_wr handshake.
module uart_tx_seq
    import uart_bus_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  tx_req_t    req,
    input  logic       tx_tbr_valid,
    output logic [7:0] tx_wdata,
    output logic       tx_wr,
    output logic       done
);

    logic [23:0] sreg;
    logic [1:0]  left;
    logic        wr_q;

    // tbr_valid is stale while tx_wr is high and for the cycle after.
    logic stall;
    assign stall = tx_wr | wr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg     <= '0;
            left     <= '0;
            wr_q     <= 1'b0;
            tx_wdata <= '0;
            tx_wr    <= 1'b0;
            done     <= 1'b0;
        end else begin
            wr_q  <= tx_wr;
            tx_wr <= 1'b0;
            done  <= 1'b0;
            if (start) begin
                sreg <= req.bytes;
                left <= req.cnt;
            end else if (left != 2'd0 && !stall && tx_tbr_valid) begin
                tx_wr    <= 1'b1;
                tx_wdata <= sreg[23:16];
                sreg     <= {sreg[15:0], 8'h00};
                left     <= left - 2'd1;
                if (left == 2'd1)
                    done <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_bus_master.sv
// UART command decoder driving single-word SRAM accesses and the CPU hold line.
module uart_bus_master
    import uart_bus_pkg::*;
#(
    parameter int ADDR_WIDTH    = 13,
    parameter int DATA_WIDTH    = 18,
    parameter int RD_LAT        = 1,
    parameter int TIMEOUT_CYC   = 1000000,
    parameter bit HOLD_AT_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_rdata,
    input  logic                  rx_d_valid,
    output logic                  rx_rd,
    output logic [7:0]            tx_wdata,
    output logic                  tx_wr,
    input  logic                  tx_tbr_valid,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_wr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  cpu_hold,
    output logic                  busy
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int LW = $clog2(RD_LAT + 2);

    state_t          state;
    logic [31:0]     sreg;
    logic [2:0]      arg_cnt;
    logic            is_wr;
    logic [TW-1:0]   to_cnt;
    logic [LW-1:0]   lat_cnt;
    logic            rd_q;
    logic            tx_start;
    tx_req_t         tx_req;
    logic            tx_done;

    // rx_d_valid is stale during the pop pulse and the cycle after it.
    logic rx_ok;
    assign rx_ok = rx_d_valid & ~rx_rd & ~rd_q;

    // 40-bit argument window: the four stored bytes plus the byte being popped.
    logic [39:0] sreg_nxt;
    assign sreg_nxt = {sreg, rx_rdata};

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            sreg      <= '0;
            arg_cnt   <= '0;
            is_wr     <= 1'b0;
            to_cnt    <= '0;
            lat_cnt   <= '0;
            rx_rd     <= 1'b0;
            rd_q      <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wr    <= 1'b0;
            cpu_hold  <= HOLD_AT_RESET;
            tx_start  <= 1'b0;
            tx_req    <= '0;
        end else begin
            rx_rd    <= 1'b0;
            rd_q     <= rx_rd;
            mem_wr   <= 1'b0;
            tx_start <= 1'b0;
            case (state)
                ST_IDLE: if (rx_ok) begin
                    rx_rd  <= 1'b1;
                    to_cnt <= '0;
                    sreg   <= '0;
                    case (rx_rdata)
                        CMD_W: begin is_wr <= 1'b1; arg_cnt <= 3'd5; state <= ST_ARGS; end
                        CMD_R: begin is_wr <= 1'b0; arg_cnt <= 3'd2; state <= ST_ARGS; end
                        CMD_H, CMD_G, CMD_P: begin
                            if (rx_rdata == CMD_H) cpu_hold <= 1'b1;
                            if (rx_rdata == CMD_G) cpu_hold <= 1'b0;
                            tx_start <= 1'b1;
                            tx_req   <= '{bytes: {RSP_ACK, 16'h0}, cnt: 2'd1};
                            state    <= ST_ACK;
                        end
                        default: begin
                            tx_start <= 1'b1;
                            tx_req   <= '{bytes: {RSP_NAK, 16'h0}, cnt: 2'd1};
                            state    <= ST_NAK;
                        end
                    endcase
                end
                ST_ARGS: if (rx_ok) begin
                    rx_rd   <= 1'b1;
                    to_cnt  <= '0;
                    sreg    <= sreg_nxt[31:0];
                    arg_cnt <= arg_cnt - 3'd1;
                    if (arg_cnt == 3'd1) begin
                        if (is_wr) begin
                            mem_addr  <= ADDR_WIDTH'(sreg_nxt[39:24]);
                            mem_wdata <= DATA_WIDTH'(sreg_nxt[23:0]);
                            mem_wr    <= 1'b1;
                            state     <= ST_EXEC_WR;
                        end else begin
                            mem_addr <= ADDR_WIDTH'(sreg_nxt[15:0]);
                            lat_cnt  <= LW'(RD_LAT);
                            state    <= ST_EXEC_RD;
                        end
                    end
                end else if (to_cnt == TW'(TIMEOUT_CYC)) begin
                    tx_start <= 1'b1;
                    tx_req   <= '{bytes: {RSP_NAK, 16'h0}, cnt: 2'd1};
                    state    <= ST_NAK;
                end else begin
                    to_cnt <= to_cnt + TW'(1);
                end
                ST_EXEC_WR: begin
                    tx_start <= 1'b1;
                    tx_req   <= '{bytes: {RSP_ACK, 16'h0}, cnt: 2'd1};
                    state    <= ST_ACK;
                end
                ST_EXEC_RD: if (lat_cnt == '0) begin
                    tx_start <= 1'b1;
                    tx_req   <= '{bytes: 24'(mem_rdata), cnt: 2'd3};
                    state    <= ST_SEND;
                end else begin
                    lat_cnt <= lat_cnt - LW'(1);
                end
                ST_SEND, ST_ACK, ST_NAK: if (tx_done) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    uart_tx_seq u_tx_seq (
        .clk          (clk),
        .rst          (rst),
        .start        (tx_start),
        .req          (tx_req),
        .tx_tbr_valid (tx_tbr_valid),
        .tx_wdata     (tx_wdata),
        .tx_wr        (tx_wr),
        .done         (tx_done)
    );

endmodule

// File: tb/tb_uart_bus_master.sv
// Bench for uart_bus_master: directed steps plus random commands against a command-level model.
module tb_uart_bus_master;

    localparam int AW = 13;
    localparam int DW = 18;
    localparam int TO = 50;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    rx_rdata = 8'h00;
    logic          rx_d_valid = 1'b0;
    logic          rx_rd;
    logic [7:0]    tx_wdata;
    logic          tx_wr;
    logic          tx_tbr_valid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_wr;
    logic [DW-1:0] mem_rdata = '0;
    logic          cpu_hold;
    logic          busy;

    always #5 clk = ~clk;

    uart_bus_master #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(1), .TIMEOUT_CYC(TO), .HOLD_AT_RESET(1'b1)
    ) dut (
        .clk(clk), .rst(rst),
        .rx_rdata(rx_rdata), .rx_d_valid(rx_d_valid), .rx_rd(rx_rd),
        .tx_wdata(tx_wdata), .tx_wr(tx_wr), .tx_tbr_valid(tx_tbr_valid),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_rdata(mem_rdata),
        .cpu_hold(cpu_hold), .busy(busy)
    );

    // Environment: receiver FIFO, transmitter with random busy time, SRAM, monitors.
    logic [7:0]    rxq[$];
    int            txq[$];
    int            wa_q[$];
    int            wd_q[$];
    logic [DW-1:0] sram [0:(1<<AW)-1];
    logic          tbr_en = 1'b1;
    int            tbr_busy = 0;
    int            viol = 0;

    assign tx_tbr_valid = tbr_en && (tbr_busy == 0);

    always @(posedge clk) begin
        if (rx_rd && rxq.size() != 0) void'(rxq.pop_front());
        rx_d_valid <= (rxq.size() != 0) && !rst;
        rx_rdata   <= (rxq.size() != 0) ? rxq[0] : 8'h00;
    end

    always @(posedge clk) begin
        if (tbr_busy > 0) tbr_busy <= tbr_busy - 1;
        if (tx_wr) begin
            if (!tx_tbr_valid) viol <= viol + 1;
            txq.push_back(int'(tx_wdata));
            tbr_busy <= int'($urandom_range(1, 3));
        end
        if (mem_wr) begin
            wa_q.push_back(int'(mem_addr));
            wd_q.push_back(int'(mem_wdata));
            sram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= sram[mem_addr];
    end

    // Reference model state
    int ref_mem[int];
    int ref_hold = 1;
    int wr_addrs[$];

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] cmd [0:5];
    int clen;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_done(input int n_tx, input string tag);
        int cyc = 0;
        while ((rxq.size() != 0 || busy || txq.size() < n_tx) && cyc < 3000) begin
            tick(1);
            cyc++;
        end
        n_tests++;
        assert (cyc < 3000) else begin
            n_fail++;
            $error("FAIL %s_timeout: still busy after %0d cycles, limit 3000", tag, cyc);
        end
        tick(4);
    endtask

    task automatic run_cmd(input string tag, input bit stall_tx);
        int exp_tx[$];
        int ea[$];
        int ed[$];
        int a, d, need;
        need = (cmd[0] == 8'h57) ? 6 : (cmd[0] == 8'h52) ? 3 : 1;
        a = (int'(cmd[1]) * 256 + int'(cmd[2])) % (1 << AW);
        if (clen < need) begin
            exp_tx.push_back(32'h15);
        end else begin
            case (cmd[0])
                8'h57: begin
                    d = (int'(cmd[3]) * 65536 + int'(cmd[4]) * 256 + int'(cmd[5])) % (1 << DW);
                    ref_mem[a] = d;
                    wr_addrs.push_back(a);
                    ea.push_back(a);
                    ed.push_back(d);
                    exp_tx.push_back(32'h06);
                end
                8'h52: begin
                    d = ref_mem.exists(a) ? ref_mem[a] : 0;
                    exp_tx.push_back((d / 65536) % 256);
                    exp_tx.push_back((d / 256) % 256);
                    exp_tx.push_back(d % 256);
                end
                8'h48: begin ref_hold = 1; exp_tx.push_back(32'h06); end
                8'h47: begin ref_hold = 0; exp_tx.push_back(32'h06); end
                8'h50: exp_tx.push_back(32'h06);
                default: exp_tx.push_back(32'h15);
            endcase
        end

        if (stall_tx) tbr_en = 1'b0;
        for (int i = 0; i < clen; i++) begin
            rxq.push_back(cmd[i]);
            tick(int'($urandom_range(0, 4)));
        end
        if (clen < need) tick(TO + 10);
        if (stall_tx) begin
            tick(40);
            chk({tag, "_stalled_tx_count"}, txq.size(), 0);
            chk({tag, "_stalled_busy"}, int'(busy), 1);
            tbr_en = 1'b1;
        end
        wait_done(exp_tx.size(), tag);

        chk({tag, "_tx_count"}, txq.size(), exp_tx.size());
        for (int i = 0; i < exp_tx.size() && i < txq.size(); i++)
            chk($sformatf("%s_tx%0d", tag, i), txq[i], exp_tx[i]);
        chk({tag, "_wr_count"}, wa_q.size(), ea.size());
        for (int i = 0; i < ea.size() && i < wa_q.size(); i++) begin
            chk({tag, "_wr_addr"}, wa_q[i], ea[i]);
            chk({tag, "_wr_data"}, wd_q[i], ed[i]);
        end
        chk({tag, "_hold"}, int'(cpu_hold), ref_hold);
        txq.delete();
        wa_q.delete();
        wd_q.delete();
    endtask

    task automatic set_cmd(input int n, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3,
                           input logic [7:0] b4, input logic [7:0] b5);
        clen = n;
        cmd[0] = b0; cmd[1] = b1; cmd[2] = b2;
        cmd[3] = b3; cmd[4] = b4; cmd[5] = b5;
    endtask

    initial begin
        int r, a;
        logic [7:0] b;

        rst = 1'b1;
        tick(2);
        chk("rst_hold", int'(cpu_hold), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_strobes", int'({rx_rd, tx_wr, mem_wr}), 0);
        chk("rst_mem_addr", int'(mem_addr), 0);
        chk("rst_mem_wdata", int'(mem_wdata), 0);
        chk("rst_tx_wdata", int'(tx_wdata), 0);
        rst = 1'b0;
        tick(2);

        set_cmd(1, 8'h47, 0, 0, 0, 0, 0); run_cmd("go", 0);
        set_cmd(1, 8'h48, 0, 0, 0, 0, 0); run_cmd("hold", 0);
        set_cmd(6, 8'h57, 8'h00, 8'h05, 8'h02, 8'hAB, 8'hCD); run_cmd("write", 0);
        set_cmd(3, 8'h52, 8'h00, 8'h05, 0, 0, 0); run_cmd("read", 0);
        set_cmd(6, 8'h57, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF); run_cmd("trunc_write", 0);
        set_cmd(1, 8'h7A, 0, 0, 0, 0, 0); run_cmd("unknown", 0);
        chk("addr_held", int'(mem_addr), 32'h1FFF);
        chk("wdata_held", int'(mem_wdata), 32'h3FFFF);
        set_cmd(2, 8'h57, 8'h00, 0, 0, 0, 0); run_cmd("timeout", 0);
        set_cmd(1, 8'h50, 0, 0, 0, 0, 0); run_cmd("ping_after_to", 0);
        set_cmd(3, 8'h52, 8'h00, 8'h05, 0, 0, 0); run_cmd("backpressure", 1);

        // Reset in the middle of argument collection
        rxq.push_back(8'h57); rxq.push_back(8'h00); rxq.push_back(8'h05);
        tick(12);
        chk("mid_args_busy", int'(busy), 1);
        rst = 1'b1;
        rxq.delete();
        tick(2);
        ref_hold = 1;
        chk("midrst_hold", int'(cpu_hold), 1);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_strobes", int'({rx_rd, tx_wr, mem_wr}), 0);
        chk("midrst_mem_addr", int'(mem_addr), 0);
        rst = 1'b0;
        tick(20);
        chk("midrst_no_tx", txq.size(), 0);
        chk("midrst_no_wr", wa_q.size(), 0);
        set_cmd(1, 8'h50, 0, 0, 0, 0, 0); run_cmd("ping_after_rst", 0);

        for (int k = 0; k < 30; k++) begin
            r = int'($urandom_range(0, 9));
            if (r <= 3) begin
                set_cmd(6, 8'h57, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
                run_cmd($sformatf("rnd%0d_w", k), 0);
            end else if (r <= 6 && wr_addrs.size() != 0) begin
                a = wr_addrs[$urandom_range(0, wr_addrs.size() - 1)];
                set_cmd(3, 8'h52, 8'(a / 256) | (8'($urandom) & 8'hE0), 8'(a % 256), 0, 0, 0);
                run_cmd($sformatf("rnd%0d_r", k), 0);
            end else if (r == 8) begin
                set_cmd(1, ($urandom_range(0, 1) != 0) ? 8'h48 : 8'h47, 0, 0, 0, 0, 0);
                run_cmd($sformatf("rnd%0d_hg", k), 0);
            end else if (r == 9) begin
                do b = 8'($urandom);
                while (b == 8'h57 || b == 8'h52 || b == 8'h48 || b == 8'h47 || b == 8'h50);
                set_cmd(1, b, 0, 0, 0, 0, 0);
                run_cmd($sformatf("rnd%0d_bad", k), 0);
            end else begin
                set_cmd(1, 8'h50, 0, 0, 0, 0, 0);
                run_cmd($sformatf("rnd%0d_p", k), 0);
            end
        end

        chk("tbr_handshake_violations", viol, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_bus_master.md
Name: uart_bus_master

Overview:
- UART-driven debug/boot initiator for the 18-bit instruction/data SRAM.
- Consumes command bytes from the UART receiver's read interface and issues single-word SRAM writes and reads.
- Returns responses through the UART transmitter's write interface.
- Controls a CPU hold line so the host can load code into SRAM while the J1 is held in reset, then release it.

Parameters:
- ADDR_WIDTH, 13, SRAM word address width.
- DATA_WIDTH, 18, SRAM word width; must be ≤ 24.
- RD_LAT, 1, SRAM read latency in cycles from address to rdata valid.
- TIMEOUT_CYC, 1000000, idle cycles allowed between argument bytes before abort.
- HOLD_AT_RESET, 1, reset value of cpu_hold.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- rx_rdata  in  8  receive byte; valid while rx_d_valid=1.
- rx_d_valid  in  1  receiver holds an unread byte.
- rx_rd  out  1  pop pulse to receiver.
- tx_wdata  out  8  transmit byte.
- tx_wr  out  1  transmit write pulse.
- tx_tbr_valid  in  1  transmit buffer empty, accepts a byte.
- mem_addr  out  ADDR_WIDTH  SRAM address.
- mem_wdata  out  DATA_WIDTH  SRAM write data.
- mem_wr  out  1  SRAM write enable.
- mem_rdata  in  DATA_WIDTH  SRAM read data.
- cpu_hold  out  1  1 = hold CPU in reset.
- busy  out  1  command in progress (state != IDLE).

Behaviour:
- Reset values: all outputs 0, except cpu_hold = HOLD_AT_RESET. Reset is async assert; design is fully synchronous otherwise.
- Reset mid-command: abandon the command with no memory write and no response, return to IDLE.
- Command set (first byte; arguments MSB first):
  - 'W' 0x57, 5 arg bytes: A1 A0 D2 D1 D0.
  - 'R' 0x52, 2 arg bytes: A1 A0.
  - 'H' 0x48: set cpu_hold=1.
  - 'G' 0x47: set cpu_hold=0.
  - 'P' 0x50: ping.
  - Any other byte: NAK.
- Address and data fields:
  - Address = {A1,A0}[ADDR_WIDTH-1:0]; upper bits ignored.
  - Data = {D2,D1,D0}[DATA_WIDTH-1:0]; upper bits ignored.
- RX handshake:
  - A byte is consumed when the FSM needs one and rx_d_valid=1.
  - rx_rdata is captured and rx_rd is pulsed high in the same cycle.
  - rx_d_valid is ignored for the cycle after each pop, to allow the flag to update.
- TX handshake:
  - tx_wr pulses one cycle with tx_wdata when tx_tbr_valid=1.
  - tx_tbr_valid is ignored for the cycle after each write.
  - tx_wdata is held stable until the next write.
- FSM states:
  - IDLE: wait for a byte; decode it.
    - W/R → ARGS with arg counter = 5 or 2.
    - H/G → update cpu_hold the cycle after the pop, → ACK.
    - P → ACK.
    - Unknown → NAK.
  - ARGS: shift each byte into a 40-bit shift register; decrement the counter; at 0 → EXEC_WR (W) or EXEC_RD (R).
    - Timeout counter resets on every pop. Reaching TIMEOUT_CYC → NAK; partial command discarded, no write.
  - EXEC_WR: mem_addr/mem_wdata driven, mem_wr=1 for exactly one cycle → ACK.
  - EXEC_RD: mem_addr driven for RD_LAT cycles, then capture mem_rdata, zero-extended to 24 bits → SEND.
  - SEND: transmit 3 bytes MSB first (bits 23:16, 15:8, 7:0) → IDLE.
  - ACK: transmit 0x06 → IDLE.
  - NAK: transmit 0x15 → IDLE.
- mem_addr and mem_wdata hold their last values outside EXEC; mem_wr is 0 outside EXEC_WR.
- Bytes arriving during EXEC/SEND/ACK/NAK stay in the receiver; they are not popped.
- Commands are processed strictly in order, one outstanding at a time.
- Write-to-done latency: mem_wr asserts 1 cycle after the last argument pop.
- The block drives the SRAM port arbitration-free. The top-level muxes this port onto the SRAM while cpu_hold=1; accesses with cpu_hold=0 are permitted but race the CPU (host's responsibility).
- Counter widths: timeout counter is $clog2(TIMEOUT_CYC+1) bits and saturates; arg counter is 3 bits.

Decomposition:
- Shared package uart_bus_pkg:
  - Command byte constants CMD_W/R/H/G/P.
  - RSP_ACK=8'h06, RSP_NAK=8'h15.
  - FSM state enum.
- Sub-module uart_tx_seq: byte-sequencing transmitter front end. Accepts up to 3 bytes plus a count, handles the tbr_valid/tx_wr handshake and post-write dead cycle, and reports done. The main FSM uses it for SEND/ACK/NAK.

Test Plan:
- Hold path: reset → cpu_hold=1. Send 'G' → cpu_hold=0, tx 0x06. Send 'H' → cpu_hold=1, tx 0x06.
- Write: send 57 00 05 02 AB CD → single mem_wr pulse, addr=0x0005, wdata=0x2ABCD; tx 0x06.
- Read: model SRAM holds 0x2ABCD at 0x0005. Send 52 00 05 → tx 02 AB CD in order, each tx_wr only when tx_tbr_valid=1.
- Truncation and wrap: send 57 FF FF FF FF FF → addr=0x1FFF, wdata=0x3FFFF. Send unknown 0x7A → tx 0x15, no mem_wr.
- Timeout (TIMEOUT_CYC=50): send 57 00 then stall 60 cycles → tx 0x15, no mem_wr. The next 'P' → tx 0x06.
- Backpressure and reset: hold tx_tbr_valid=0 during a read response → no tx_wr; release → 3 bytes sent. Assert rst mid-ARGS → outputs return to reset values, no response; the following 'P' → 0x06.
